// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT run cycles.
// Results (sum, cout, ovf, sum_f) are registered and only change on completion.
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH:0]   sum_f
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       msb_q, msb_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] opb_in;
  logic             last_digit;

  always_comb begin
    dsum       = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
    res_shift  = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);
    opb_in     = sub ? ~b : b;
    last_digit = (cnt_q == CW'(N - 1));

    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          opa_d   = a;
          opb_d   = opb_in;
          carry_d = sub;
          cnt_d   = '0;
          msb_d   = {a[WIDTH-1], opb_in[WIDTH-1]};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = dsum[DIGIT];
          ovf_d   = (msb_q[1] == msb_q[0]) && (res_shift[WIDTH-1] != msb_q[1]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      msb_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign sum_f = {cout_q, sum_q};

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: 8-bit/2-digit vectors and handshake cases,
// plus exhaustive sweeps of 4-bit instances with DIGIT=1 and DIGIT=4.
module tb_add_sub_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic [8:0] sum_f;

  logic       sm_start = 1'b0, sm_sub = 1'b0;
  logic [3:0] sm_a = '0, sm_b = '0;
  logic       s1_busy, s1_done, s1_cout, s1_ovf;
  logic [3:0] s1_sum;
  logic [4:0] s1_sum_f;
  logic       s4_busy, s4_done, s4_cout, s4_ovf;
  logic [3:0] s4_sum;
  logic [4:0] s4_sum_f;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .sum_f(sum_f)
  );

  add_sub_serial #(.WIDTH(4), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(sm_start), .sub(sm_sub), .a(sm_a), .b(sm_b),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf),
    .sum_f(s1_sum_f)
  );

  add_sub_serial #(.WIDTH(4), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .start(sm_start), .sub(sm_sub), .a(sm_a), .b(sm_b),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .ovf(s4_ovf),
    .sum_f(s4_sum_f)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Called at the negedge of the first RUN cycle; returns at the done cycle.
  task automatic wait_done(output int lat, output int nb);
    lat = 1;
    nb  = 0;
    while (!done && lat < 12) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_main(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                          input string tag);
    int lat, nb;
    start = 1'b1; sub = s; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    sub = ~s;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(lat, nb);
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd4);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic sweep();
    int full, sa, sb, r, lat1, lat4;
    logic [10:0] exp1, exp4, act1, act4;
    logic [3:0] bx, sm;
    logic c, o;
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          sm_start = 1'b1; sm_sub = s[0]; sm_a = ia[3:0]; sm_b = ib[3:0];
          @(negedge clk);
          sm_start = 1'b0;
          lat1 = 0; lat4 = 0; act1 = '0; act4 = '0;
          for (int cyc = 1; cyc <= 6; cyc++) begin
            if (s1_done && lat1 == 0) begin
              lat1 = cyc;
              act1 = {4'(cyc), s1_cout, s1_sum_f, s1_ovf};
            end
            if (s4_done && lat4 == 0) begin
              lat4 = cyc;
              act4 = {4'(cyc), s4_cout, s4_sum_f, s4_ovf};
            end
            @(negedge clk);
          end
          bx   = (s != 0) ? ~ib[3:0] : ib[3:0];
          full = ia + int'(bx) + s;
          sm   = full[3:0];
          c    = full[4];
          sa   = (ia >= 8) ? ia - 16 : ia;
          sb   = (ib >= 8) ? ib - 16 : ib;
          r    = (s != 0) ? sa - sb : sa + sb;
          o    = (r > 7) || (r < -8);
          exp1 = {4'd5, c, c, sm, o};
          exp4 = {4'd2, c, c, sm, o};
          chk($sformatf("sweep_w4d1 s=%0d a=%0d b=%0d", s, ia, ib), 32'(act1), 32'(exp1));
          chk($sformatf("sweep_w4d4 s=%0d a=%0d b=%0d", s, ia, ib), 32'(act4), 32'(exp4));
        end
      end
    end
  endtask

  initial begin
    int lat, nb;
    logic saw_done;

    vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h3C, 8'hC4, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'h00);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sum_f", 32'(sum_f), 32'h000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_main(vecs[i].sub, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_sum_f", i), 32'(sum_f), 32'({vecs[i].cout, vecs[i].sum}));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_hold", i), 32'({ovf, sum_f}),
          32'({vecs[i].ovf, vecs[i].cout, vecs[i].sum}));
    end

    // Requests during RUN are ignored; start dropped before the done cycle samples it.
    start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
    @(negedge clk);
    sub = 1'b1; a = 8'hAA; b = 8'h55;
    wait_done(lat, nb);
    start = 1'b0;
    chk("ign_latency", 32'(lat), 32'd5);
    chk("ign_sum", 32'(sum_f), 32'h030);
    @(negedge clk);
    chk("ign_idle_after", 32'({busy, done}), 32'd0);

    // Back-to-back: start in the done cycle.
    start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    chk("b2b_first_latency", 32'(lat), 32'd5);
    chk("b2b_first_sum", 32'(sum), 32'h30);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_t6", 32'(busy), 32'd1);
    chk("b2b_hold_during_run", 32'(sum), 32'h30);
    wait_done(lat, nb);
    chk("b2b_second_latency", 32'(lat), 32'd5);
    chk("b2b_second_sum", 32'(sum_f), 32'h003);
    @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_outputs", 32'({cout, ovf, sum_f}), 32'd0);
    saw_done = 1'b0;
    repeat (6) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_main(1'b0, 8'h01, 8'h01, "after_abort");
    chk("after_abort_sum", 32'(sum), 32'h02);
    @(negedge clk);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_sum_f", 32'(sum_f), 32'h000);
    @(negedge clk);
    chk("rst_start_no_done", 32'({busy, done}), 32'd0);

    sweep();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
